// File: rtl/fib_capture.sv
// Fibonacci-stage capture block: samples a sequence value, queues each change in a
// small FIFO and exposes it over a Wishbone slave with DATA/STATUS/CTRL registers.
module fib_capture #(
    parameter int          WIDTH     = 30,
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0100
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic [WIDTH-1:0] value,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic             irq
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_last;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_ovf;
    logic             r_en;
    logic             r_ie;
    logic             r_ack;
    logic             r_pop_pend;
    logic             r_irq;
    logic [31:0]      r_dat;

    logic        w_sel;
    logic        w_req;
    logic        w_wr;
    logic        w_rd;
    logic [1:0]  w_idx;
    logic        w_empty;
    logic        w_full;
    logic        w_chg;
    logic        w_pop;
    logic        w_push;
    logic        w_ovf_set;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_sel   = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign w_req   = wbs_cyc_i & wbs_stb_i & w_sel & ~r_ack;
    assign w_wr    = w_req & wbs_we_i;
    assign w_rd    = w_req & ~wbs_we_i;
    assign w_idx   = wbs_adr_i[3:2];
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

    // A pop in the ack cycle frees the slot a simultaneous push needs, so a full FIFO still accepts it.
    assign w_chg     = r_en & (r_s2 != r_last);
    assign w_pop     = r_ack & r_pop_pend;
    assign w_push    = w_chg & (~w_full | w_pop);
    assign w_ovf_set = w_chg & w_full & ~w_pop;

    assign w_unused = &{1'b0, wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i[31:2]};

    always_comb begin
        w_rdata = '0;
        case (w_idx)
            2'd0: begin
                if (!w_empty) w_rdata[WIDTH-1:0] = r_mem[r_rptr];
            end
            2'd1: begin
                w_rdata[CW-1:0] = r_count;
                w_rdata[8]      = w_empty;
                w_rdata[9]      = w_full;
                w_rdata[10]     = r_ovf;
            end
            2'd2:    w_rdata[1:0] = {r_ie, r_en};
            default: w_rdata = '0;
        endcase
    end

    // last_val follows s2 every cycle: equal to loading on change when enabled, tracking when not.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_last <= '0;
        end else begin
            r_s1   <= value;
            r_s2   <= r_s1;
            r_last <= r_s2;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_push) r_mem[r_wptr] <= r_s2;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_ovf_set)                 r_ovf <= 1'b1;
            else if (w_wr && w_idx == 2'd1) r_ovf <= 1'b0;
        end
    end

    // Read data and the pop decision are captured at request time; the pop itself lands in the ack cycle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_ack      <= 1'b0;
            r_dat      <= '0;
            r_pop_pend <= 1'b0;
            r_en       <= 1'b0;
            r_ie       <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_ack      <= w_req;
            r_dat      <= w_req ? w_rdata : 32'd0;
            r_pop_pend <= w_rd & (w_idx == 2'd0) & ~w_empty;
            if (w_wr && w_idx == 2'd2) begin
                r_en <= wbs_dat_i[0];
                r_ie <= wbs_dat_i[1];
            end
            r_irq <= r_ie & (~w_empty | r_ovf);
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign irq       = r_irq;

endmodule

// File: tb/tb_fib_capture.sv
// Directed bench for fib_capture: register-access vector table plus hand-timed
// sequences for overflow, push/pop collisions and reset mid-transaction.
module tb_fib_capture;

    localparam logic [31:0] A_DATA = 32'h3000_0100;
    localparam logic [31:0] A_STAT = 32'h3000_0104;
    localparam logic [31:0] A_CTRL = 32'h3000_0108;
    localparam logic [31:0] A_R3   = 32'h3000_010C;
    localparam logic [31:0] A_BAD  = 32'h3000_0200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [29:0] value;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_i;
    logic        ack;
    logic [31:0] dat_o;
    logic        irq;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] rdat;
    int          lat;
    int          acks;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
        logic        chk;
    } vec_t;

    localparam int NV = 11;
    vec_t tbl [NV];
    logic [29:0] drain1 [4];
    logic [29:0] drain2 [4];

    always #5 clk = ~clk;

    fib_capture #(.WIDTH(30), .DEPTH(4), .BASE_ADDR(32'h3000_0100)) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .value    (value),
        .wbs_stb_i(stb),
        .wbs_cyc_i(cyc),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(dat_i),
        .wbs_ack_o(ack),
        .wbs_dat_o(dat_o),
        .irq      (irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output int n);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d;
        rd = '0; n = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (ack === 1'b1) begin
                n  = i;
                rd = dat_o;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        int          n;
        bus(1'b0, a, 32'd0, r, n);
        check({name, "_lat"}, 32'(n), 32'd1);
        check(name, r, exp);
    endtask

    task automatic wr(input string name, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        int          n;
        bus(1'b1, a, d, r, n);
        check({name, "_lat"}, 32'(n), 32'd1);
    endtask

    task automatic hold(input logic [29:0] v, input int n);
        value = v;
        repeat (n) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b0, A_STAT, 32'd0,          32'h100, 1'b1};
        tbl[1]  = '{1'b0, A_CTRL, 32'd0,          32'h0,   1'b1};
        tbl[2]  = '{1'b0, A_R3,   32'd0,          32'h0,   1'b1};
        tbl[3]  = '{1'b1, A_R3,   32'hFFFF_FFFF,  32'h0,   1'b0};
        tbl[4]  = '{1'b0, A_R3,   32'd0,          32'h0,   1'b1};
        tbl[5]  = '{1'b1, A_CTRL, 32'h2,          32'h0,   1'b0};
        tbl[6]  = '{1'b0, A_CTRL, 32'd0,          32'h2,   1'b1};
        tbl[7]  = '{1'b0, A_DATA, 32'd0,          32'h0,   1'b1};
        tbl[8]  = '{1'b0, A_STAT, 32'd0,          32'h100, 1'b1};
        tbl[9]  = '{1'b1, A_CTRL, 32'h0,          32'h0,   1'b0};
        tbl[10] = '{1'b0, A_CTRL, 32'd0,          32'h0,   1'b1};
        drain1 = '{30'd1, 30'd2, 30'd3, 30'd5};
        drain2 = '{30'd2, 30'd3, 30'd5, 30'd13};

        rst_n = 1'b0; value = 30'd7;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'hF; adr = '0; dat_i = '0;

        // reset state before any clock edge
        #3;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        tick(); tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            bus(tbl[i].w, tbl[i].a, tbl[i].d, rdat, lat);
            check($sformatf("tbl%0d_lat", i), 32'(lat), 32'd1);
            if (tbl[i].chk) check($sformatf("tbl%0d_dat", i), rdat, tbl[i].exp);
        end
        check("idle_irq", 32'(irq), 32'd0);

        // held request: one-cycle ack, then a fresh ack only on the next request cycle
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_STAT;
        tick(); check("hold_ack1", 32'(ack), 32'd1);
        tick(); check("hold_ack0", 32'(ack), 32'd0);
        tick(); check("hold_ack2", 32'(ack), 32'd1);
        cyc = 1'b0; stb = 1'b0;
        tick();

        // unselected address never acks
        acks = 0;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_BAD;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ack === 1'b1) acks++;
        end
        cyc = 1'b0; stb = 1'b0;
        tick();
        check("unsel_acks", 32'(acks), 32'd0);

        // fill and drain
        wr("ctrl_w3", A_CTRL, 32'h3);
        hold(30'd1, 4); hold(30'd2, 4); hold(30'd3, 4); hold(30'd5, 4);
        rd_chk("fill_stat", A_STAT, 32'h204);
        check("fill_irq", 32'(irq), 32'd1);
        for (int i = 0; i < 4; i++) rd_chk($sformatf("drain1_%0d", i), A_DATA, 32'(drain1[i]));
        tick();
        check("drain_irq", 32'(irq), 32'd0);
        rd_chk("drain_stat", A_STAT, 32'h100);
        rd_chk("empty_data", A_DATA, 32'h0);
        rd_chk("empty_stat", A_STAT, 32'h100);

        // overflow while full, then clear
        hold(30'd1, 4); hold(30'd2, 4); hold(30'd3, 4); hold(30'd5, 4);
        rd_chk("refill_stat", A_STAT, 32'h204);
        hold(30'd8, 4);
        rd_chk("ovf_stat", A_STAT, 32'h604);
        check("ovf_irq", 32'(irq), 32'd1);
        wr("stat_clr", A_STAT, 32'h0);
        rd_chk("clr_stat", A_STAT, 32'h204);

        // pop in the same cycle as a push at count=4
        value = 30'd13;
        tick();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_DATA;
        tick();
        check("coll_ack", 32'(ack), 32'd1);
        check("coll_dat", dat_o, 32'd1);
        cyc = 1'b0; stb = 1'b0;
        tick();
        rd_chk("coll_stat", A_STAT, 32'h204);

        // STATUS write coinciding with a new overflow: set wins
        value = 30'd21;
        tick(); tick();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_STAT; dat_i = 32'h0;
        tick();
        check("setwin_ack", 32'(ack), 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
        rd_chk("setwin_stat", A_STAT, 32'h604);
        wr("stat_clr2", A_STAT, 32'h0);
        rd_chk("clr2_stat", A_STAT, 32'h204);
        for (int i = 0; i < 4; i++) rd_chk($sformatf("drain2_%0d", i), A_DATA, 32'(drain2[i]));
        rd_chk("drain2_stat", A_STAT, 32'h100);

        // reset during a DATA read with three entries queued
        hold(30'd34, 4); hold(30'd55, 4); hold(30'd89, 4);
        rd_chk("three_stat", A_STAT, 32'h003);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_DATA;
        tick();
        check("midrd_ack", 32'(ack), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_dat", dat_o, 32'd0);
        check("midrst_irq", 32'(irq), 32'd0);
        cyc = 1'b0; stb = 1'b0;
        tick(); tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        rd_chk("post_stat", A_STAT, 32'h100);
        rd_chk("post_ctrl", A_CTRL, 32'h0);
        hold(30'd144, 4);
        rd_chk("post_nocap", A_STAT, 32'h100);
        check("post_irq", 32'(irq), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fib_capture.md
FIB_CAPTURE -- requirements
Module: fib_capture

Interface
REQ-001 Parameter WIDTH, default 30: width of the captured sequence value.
REQ-002 Parameter DEPTH, default 4: capture FIFO entries; power of two, 2..16.
REQ-003 Parameter BASE_ADDR, default 32'h3000_0100: Wishbone base; bits [3:0] SHALL be zero.
REQ-004 Ports, one clock domain; reset is asynchronous and active-low:
- wb_clk_i  in  1  sole clock
- wb_rst_ni  in  1  asynchronous active-low reset
- value  in  WIDTH  sequence value from the fibonacci stage
- wbs_stb_i  in  1  strobe
- wbs_cyc_i  in  1  cycle
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects (ignored; full-word access)
- wbs_adr_i  in  32  address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- irq  out  1  level interrupt

Function
REQ-005 Sampling: value SHALL pass through two flip-flop stages (s1, s2); s2 is the sampled value.
REQ-006 Change detect: when CTRL.en=1 and s2 differs from last_val, the block SHALL push s2 into the FIFO and load last_val<=s2 in the same cycle.
REQ-007 Push while full: the entry SHALL be dropped, FIFO contents SHALL remain unchanged, STATUS.ovf SHALL be set (sticky), and last_val SHALL still update.
REQ-008 When CTRL.en=0 there SHALL be no pushes, and last_val SHALL track s2 every cycle, so enabling does not capture a stale transition.
REQ-009 Decode: an access is selected when wbs_adr_i[31:4]==BASE_ADDR[31:4]; the register index is wbs_adr_i[3:2].
REQ-010 Register map:
- 0 DATA (RO): {zero-pad, FIFO head}.
- 1 STATUS: [4:0] count, [8] empty, [9] full, [10] ovf. Any write clears ovf.
- 2 CTRL (RW): [0] en, [1] ie. Reset value 0.
- 3: reads 0, writes ignored.
REQ-011 Handshake: when cyc&stb&selected and ack=0, ack SHALL be 1 on the next cycle, for exactly one cycle; the next ack requires a new request cycle.
REQ-012 wbs_dat_o SHALL be valid while ack=1 and 0 otherwise.
REQ-013 Unselected addresses SHALL never produce ack.
REQ-014 A DATA read SHALL pop the FIFO in the ack cycle.
REQ-015 A DATA read while empty SHALL return 0 and SHALL NOT alter the pointers.
REQ-016 Simultaneous push and pop when non-empty: count SHALL be unchanged and both operations SHALL take effect.
REQ-017 Simultaneous push and pop when full: the pop frees space, so the push SHALL be accepted and ovf SHALL NOT be set.
REQ-018 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-019 irq SHALL equal registered ie & (~empty | ovf), updating one cycle after its inputs change.
REQ-020 A STATUS write clearing ovf in the same cycle as a new overflow: set SHALL win.

Reset
REQ-021 While wb_rst_ni=0, regardless of clock:
- s1, s2, last_val, pointers, count, ovf, CTRL = 0
- wbs_ack_o = 0, wbs_dat_o = 0, irq = 0
REQ-022 Reset mid-transaction SHALL abort the transaction with no ack and SHALL empty the FIFO.
REQ-023 Release SHALL take effect on the first rising edge of wb_clk_i after wb_rst_ni rises; no capture SHALL occur until CTRL.en is written.

Verification
REQ-024 Write CTRL=3, drive value 1,2,3,5 with each held 4 cycles -> count=4, full=1, irq=1; four DATA reads return 1,2,3,5; then empty=1 and irq=0.
REQ-025 With the FIFO full, change value to 8 -> ovf=1, head still 1; write STATUS -> ovf=0.
REQ-026 Hold a DATA read in the same cycle a push occurs at count=4 -> count stays 4, ovf=0, and the new value becomes the tail.
REQ-027 Read DATA while empty -> ack after 1 cycle, data 0, count 0.
REQ-028 Access 0x3000_0200 -> no ack for 10 cycles.
REQ-029 Assert wb_rst_ni=0 mid-read with count=3 -> ack=0, count=0, CTRL=0; value changes after release are not captured.
